scedma_ramarb: RTL
==================

SCEDMA_RAMARB -- requirements
Module: scedma_ramarb

Interface
REQ-001 Parameter CHCNT, default 4: number of requesting channel ports (2..8).
REQ-002 Parameter AW, default 12: RAM word-address width.
REQ-003 Parameter DW, default 32: data width.
REQ-004 clk  in  1  single clock; all logic is on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 ch_rd  in  CHCNT  per-channel read request.
REQ-007 ch_wr  in  CHCNT  per-channel write request.
REQ-008 ch_segaddr  in  CHCNT*AW  per-channel segment base word address.
REQ-009 ch_segsize  in  CHCNT*AW  per-channel segment size in words.
REQ-010 ch_segptr  in  CHCNT*AW  per-channel offset within the segment.
REQ-011 ch_wdat  in  CHCNT*DW  per-channel write data.
REQ-012 ch_porttype  in  CHCNT*2  per-channel type: 0 NONE, 1 RO, 2 WO, 3 RW.
REQ-013 ch_lock  in  CHCNT  per-channel burst-lock request (used only with the macro in REQ-031).
REQ-014 ch_ready  out  CHCNT  one-hot grant: the request was accepted this cycle.
REQ-015 ch_rdat  out  DW  read data, shared by all channels.
REQ-016 ch_rdatvld  out  CHCNT  one-hot read-data valid.
REQ-017 ch_err  out  CHCNT  one-cycle pulse for a rejected request.
REQ-018 ram_cs, ram_we  out  1 each  RAM chip select and write enable.
REQ-019 ram_addr  out  AW  RAM word address.
REQ-020 ram_wdat  out  DW  RAM write data.
REQ-021 ram_rdat  in  DW  RAM read data, valid one cycle after a ram_cs read.

Function
REQ-022 Request i is active when ch_rd[i] or ch_wr[i] is 1; if both are 1, the request is a write.
- Legality: a request is legal when segptr < segsize and the porttype allows the operation.
- RO allows reads only; WO allows writes only; RW allows both; NONE allows neither.
REQ-023 Arbitration is round-robin with a registered last-grant pointer.
- Search starts at (last+1) mod CHCNT and grants the first active request, legal or not.
- At most one grant per cycle.
- The pointer updates only on a grant.
REQ-024 Granted legal request: combinationally, in the same cycle:
- ch_ready[i]=1, ram_cs=1;
- ram_we=1 for a write, 0 for a read;
- ram_addr = segaddr+segptr, truncated to AW bits;
- ram_wdat = ch_wdat[i].
REQ-025 Granted illegal request: in the same cycle, ch_ready[i]=1 and ch_err[i]=1, ram_cs=0; the request is consumed.
REQ-026 Read return: ch_rdatvld[i]=1 exactly one cycle after the grant, with ch_rdat=ram_rdat.
- The return is tracked by a registered one-hot tag.
- Back-to-back reads, including from different channels, return in grant order at one per cycle.
REQ-027 Idle cycle (no active request): ram_cs=0, ram_we=0, ram_addr=0, ram_wdat=0; the pointer holds.
REQ-028 Throughput: a single continuously requesting channel is granted every cycle.
- N active channels are each granted once every N cycles.
REQ-029 A request whose segaddr+segptr overflows AW bits is still legal; the address wraps modulo 2^AW.

Reset
REQ-030 While rst=1:
- last-grant pointer = CHCNT-1, so channel 0 has first priority;
- read tag = 0, lock counter = 0;
- ch_ready, ch_rdatvld, ch_err, ram_cs and ram_we are all 0.
- A read granted in the cycle before rst asserts produces no ch_rdatvld.

Configuration
REQ-031 Macro SCEDMA_RAMARB_LOCK_EN.
- When defined, a channel granted with ch_lock[i]=1 holds priority on following cycles while its request and ch_lock stay high, for at most 16 consecutive grants (4-bit counter).
- After the 16th consecutive grant, or when the lock drops, the pointer advances normally and the counter clears.
- When undefined, ch_lock is ignored and the counter is not built.

Verification
REQ-032 Channels 0..3 all issue RW reads with segsize 64, segptr 0, segaddr 0/64/128/192 -> grants in order 0,1,2,3,0; ram_addr 0,64,128,192,0; ch_rdatvld follows each grant one cycle later.
REQ-033 Channel 1 is RO, issues a write, segptr 5, segsize 64 -> ch_ready[1]=1, ch_err[1]=1, ram_cs=0, no rdatvld.
- Same channel reads with segptr 64, segsize 64 -> ch_err[1]=1.
REQ-034 Channel 2 asserts rd and wr together, RW, segaddr 0x100, segptr 3 -> ram_we=1, ram_addr=0x103, ram_wdat=ch_wdat[2].
REQ-035 Read granted to channel 0, then rst pulsed in the next cycle -> ch_rdatvld stays 0; after reset the first grant goes to channel 0.
REQ-036 With SCEDMA_RAMARB_LOCK_EN, channel 0 locked and channels 0 and 1 requesting continuously -> channel 0 gets 16 consecutive grants, then channel 1 is granted.
- Without the macro -> grants alternate 0,1,0,1.

Source files
------------

// File: rtl/scedma_ramarb.sv
// scedma_ramarb: round-robin arbiter sharing one single-port RAM among
// CHCNT DMA channel ports. Each channel addresses the RAM through its own
// segment (base + offset). The arbiter rejects requests that fall outside
// the segment or that the port type forbids. Read data returns one cycle
// after the grant.
// Optional feature: define SCEDMA_RAMARB_LOCK_EN to honour ch_lock. A locked
// channel keeps priority for up to 16 consecutive grants.

// Per-channel decode: request activity, direction, legality, RAM address.
module scedma_ramarb_lane #(
  parameter int AW = 12
) (
  input  logic          i_rd,
  input  logic          i_wr,
  input  logic [AW-1:0] i_segaddr,
  input  logic [AW-1:0] i_segsize,
  input  logic [AW-1:0] i_segptr,
  input  logic [1:0]    i_ptype,
  output logic          o_act,
  output logic          o_wr,
  output logic          o_legal,
  output logic [AW-1:0] o_addr
);
  assign o_act  = i_rd | i_wr;
  assign o_wr   = i_wr;          // rd+wr together counts as a write
  assign o_addr = i_segaddr + i_segptr;  // wraps modulo 2^AW

  // port type bit0 = read allowed (RO/RW), bit1 = write allowed (WO/RW)
  always_comb begin
    o_legal = (i_segptr < i_segsize) && (i_wr ? i_ptype[1] : i_ptype[0]);
  end
endmodule

module scedma_ramarb #(
  parameter int CHCNT = 4,
  parameter int AW    = 12,
  parameter int DW    = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [CHCNT-1:0]    ch_rd,
  input  logic [CHCNT-1:0]    ch_wr,
  input  logic [CHCNT*AW-1:0] ch_segaddr,
  input  logic [CHCNT*AW-1:0] ch_segsize,
  input  logic [CHCNT*AW-1:0] ch_segptr,
  input  logic [CHCNT*DW-1:0] ch_wdat,
  input  logic [CHCNT*2-1:0]  ch_porttype,
  input  logic [CHCNT-1:0]    ch_lock,
  output logic [CHCNT-1:0]    ch_ready,
  output logic [DW-1:0]       ch_rdat,
  output logic [CHCNT-1:0]    ch_rdatvld,
  output logic [CHCNT-1:0]    ch_err,
  output logic               ram_cs,
  output logic               ram_we,
  output logic [AW-1:0]       ram_addr,
  output logic [DW-1:0]       ram_wdat,
  input  logic [DW-1:0]       ram_rdat
);
  localparam int LW = (CHCNT > 1) ? $clog2(CHCNT) : 1;

  logic [CHCNT-1:0][AW-1:0] w_segaddr, w_segsize, w_segptr, w_addr;
  logic [CHCNT-1:0][DW-1:0] w_wdat;
  logic [CHCNT-1:0][1:0]    w_ptype;
  logic [CHCNT-1:0]         w_act, w_wr, w_legal;

  assign w_segaddr = ch_segaddr;
  assign w_segsize = ch_segsize;
  assign w_segptr  = ch_segptr;
  assign w_wdat    = ch_wdat;
  assign w_ptype   = ch_porttype;

  for (genvar g = 0; g < CHCNT; g++) begin : g_lane
    scedma_ramarb_lane #(.AW(AW)) u_lane (
      .i_rd      (ch_rd[g]),
      .i_wr      (ch_wr[g]),
      .i_segaddr (w_segaddr[g]),
      .i_segsize (w_segsize[g]),
      .i_segptr  (w_segptr[g]),
      .i_ptype   (w_ptype[g]),
      .o_act     (w_act[g]),
      .o_wr      (w_wr[g]),
      .o_legal   (w_legal[g]),
      .o_addr    (w_addr[g])
    );
  end

  logic [LW-1:0]    r_last;     // last granted channel
  logic [CHCNT-1:0] r_rtag;     // one-hot owner of the read in flight
  logic             w_gnt_vld;
  logic [LW-1:0]    w_gnt_idx;
  logic [LW-1:0]    w_cand;
  logic [CHCNT-1:0] w_gnt_oh;
  logic             w_gl;       // granted and legal: the RAM is accessed

`ifdef SCEDMA_RAMARB_LOCK_EN
  logic [3:0] r_lock_cnt;       // consecutive locked grants so far (0 = no lock run)
  logic       w_hold;
  assign w_hold = (r_lock_cnt != 4'd0) && w_act[r_last] && ch_lock[r_last];
`else
  logic w_unused;
  assign w_unused = ^ch_lock;
`endif

  // round-robin search from last+1; a held lock overrides the search
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    for (int k = 1; k <= CHCNT; k++) begin
      w_cand = LW'((int'(r_last) + k) % CHCNT);
      if (!w_gnt_vld && w_act[w_cand]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = w_cand;
      end
    end
`ifdef SCEDMA_RAMARB_LOCK_EN
    if (w_hold) begin
      w_gnt_vld = 1'b1;
      w_gnt_idx = r_last;
    end
`endif
    if (rst) w_gnt_vld = 1'b0;
  end

  assign w_gnt_oh = w_gnt_vld ? (CHCNT'(1) << w_gnt_idx) : '0;
  assign w_gl     = w_gnt_vld && w_legal[w_gnt_idx];

  // grant/error handshake and RAM drive; RAM bus is zero unless accessed
  always_comb begin
    ch_ready = w_gnt_oh;
    ch_err   = w_gl ? '0 : w_gnt_oh;
    ram_cs   = w_gl;
    ram_we   = w_gl && w_wr[w_gnt_idx];
    ram_addr = w_gl ? w_addr[w_gnt_idx] : '0;
    ram_wdat = w_gl ? w_wdat[w_gnt_idx] : '0;
  end

  assign ch_rdatvld = r_rtag;
  assign ch_rdat    = ram_rdat;

  // last-grant pointer moves only on a grant; reset favours channel 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_last <= LW'(CHCNT - 1);
    else if (w_gnt_vld) r_last <= w_gnt_idx;
  end

  // tag the owner of a legal read so its data is flagged next cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rtag <= '0;
    else     r_rtag <= (w_gl && !w_wr[w_gnt_idx]) ? w_gnt_oh : '0;
  end

`ifdef SCEDMA_RAMARB_LOCK_EN
  // count a locked run; the 16th grant ends it so the pointer moves on
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_lock_cnt <= 4'd0;
    else if (w_gnt_vld && ch_lock[w_gnt_idx])
      r_lock_cnt <= w_hold ? ((r_lock_cnt == 4'd15) ? 4'd0 : r_lock_cnt + 4'd1) : 4'd1;
    else
      r_lock_cnt <= 4'd0;
  end
`endif
endmodule
